vga_frame_sched: RTL and testbench
==================================

Name: vga_frame_sched

Overview:
- Frame-level scheduler for the game datapath.
- Watches the VGA timing outputs (vsync, y_pos) and, once per N frames, runs the game-state update clients in a fixed priority order using a go/done handshake.
- Confines all updates to vertical blanking, so the pixel datapath never sees half-updated state.
- Sits between the VGA timing block and the bird/pipe/score/collision update logic, in the VGA pixel clock domain.

Parameters:
- N_CLIENTS, 4, number of update clients; client 0 is serviced first.
- FRAME_DIV, 1, run one update sequence every FRAME_DIV vsync edges (1..255).
- TIMEOUT, 1023, max cycles a client may hold its grant before it is forcibly retired.
- V_ACTIVE, 480, number of active lines; y_pos below this value is visible video.

Ports:
- clk  input  1  pixel clock; same clock that drives the VGA counter.
- n_rst  input  1  synchronous, active-low reset.
- vsync  input  1  vertical sync from the VGA counter, active high.
- y_pos  input  10  current line from the VGA counter.
- enable  input  1  allows new update sequences to start.
- client_en  input  N_CLIENTS  per-client enable; a disabled client is skipped.
- client_done  input  N_CLIENTS  client k pulses or holds high to finish its update.
- clr_err  input  1  clears the sticky error flags.
- client_go  output  N_CLIENTS  one-hot level grant; at most one bit high.
- busy  output  1  high while any client is granted.
- frame_tick  output  1  one-cycle pulse when a sequence completes.
- frame_cnt  output  16  count of completed sequences, wraps at 16'hFFFF->0.
- overrun  output  1  sticky: a sequence was still busy when active video started, or a vsync edge arrived while busy.
- timeout_err  output  N_CLIENTS  sticky per-client timeout flags.

Behaviour:
- Reset (n_rst low at a clk edge) forces all outputs to 0 on that edge: client_go, busy, frame_tick, frame_cnt, overrun, timeout_err. The FSM goes to IDLE and the divider counter goes to 0. Reset mid-sequence drops the grant immediately; no done is awaited.
- vsync_q is registered each cycle. vs_edge = vsync & ~vsync_q.
- Divider:
  - Counts vs_edge while in IDLE.
  - A sequence is started when enable is high and the divider equals FRAME_DIV-1; the divider then resets to 0.
  - If enable is low, vs_edge is ignored and the divider holds.
- FSM states:
  - IDLE -> SELECT on start.
  - SELECT: finds the lowest index k >= idx with client_en[k]=1, then -> GRANT. If none remain, -> DONE. SELECT takes one cycle.
  - GRANT: client_go[k]=1 and busy=1; the watchdog counts cycles. On client_done[k]=1 or watchdog == TIMEOUT: clear go, set idx=k+1, -> SELECT. On timeout, also set timeout_err[k].
  - DONE: pulse frame_tick for one cycle, increment frame_cnt, -> IDLE.
- Latency:
  - vs_edge at cycle t -> SELECT at t+1 -> client_go asserted at t+2.
  - client_done high at cycle c -> go low at c+1 -> next go at c+2.
- client_done is only sampled for the granted client. done for a non-granted client is ignored.
- client_en is sampled in SELECT only. Deasserting it mid-grant does not revoke the grant.
- Deasserting enable mid-sequence does not abort; the current sequence finishes.
- vs_edge while busy: the edge is dropped, overrun is set, and the divider is not advanced.
- Active video: if y_pos == 0 while busy=1, overrun is set and the sequence continues.
- Simultaneous events:
  - done and timeout in the same cycle: treated as done, no timeout_err.
  - clr_err and a new error in the same cycle: the new error wins (flag stays set).
- All client_en=0: a started sequence passes through SELECT -> DONE. frame_tick still pulses; client_go is never asserted.

Optional Feature:
- Macro: FRAME_SCHED_PERF_EN.
- Defined: adds output max_busy [15:0]. This is the largest number of cycles from the first SELECT to DONE of any sequence, saturating at 16'hFFFF. It is reset by n_rst and cleared by clr_err.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- vga_pkg holds:
  - sched_state_t enum {IDLE, SELECT, GRANT, DONE};
  - V_ACTIVE, H_TOTAL and V_TOTAL constants, shared with the VGA counter.
- One sub-module, sched_watchdog: a load/clear counter with terminal-count output at TIMEOUT, used in GRANT.

Test Plan:
- Normal sequence: N=4, all enabled, each client raises done 5 cycles after its go -> go order 0,1,2,3 with one-hot grants; frame_tick one cycle; frame_cnt=1; no errors.
- Skip: client_en=4'b1010 -> only go[1] and go[3] are asserted; frame_tick still pulses.
- Timeout: TIMEOUT=16, client 2 never responds -> go[2] is dropped after 16 cycles; timeout_err=4'b0100; client 3 is then granted. clr_err clears the flag next cycle.
- Overrun: client 0 holds its grant until y_pos wraps to 0 -> overrun=1. A second vsync edge while still busy keeps overrun=1 and does not advance frame_cnt.
- Divider and enable: FRAME_DIV=3, 9 vsync edges -> 3 sequences. With enable=0 across edges -> no go and the divider holds.
- Reset mid-GRANT: n_rst low while go[1]=1 -> all outputs are 0 on the next edge; after release, the next eligible vsync edge restarts from client 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and scheduler state encoding, common to the
// VGA counter and the frame scheduler.
package vga_pkg;

  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {IDLE, SELECT, GRANT, DONE} sched_state_t;

  // True for lines that belong to vertical blanking.
  function automatic logic is_vblank(input logic [9:0] y);
    return (int'(y) >= V_ACTIVE) && (int'(y) < V_TOTAL);
  endfunction

endpackage

// File: rtl/vga_frame_sched_watchdog.sv
// Grant watchdog: loads to 1 on the cycle before a grant, counts grant cycles,
// and flags terminal count when the grant has lasted TIMEOUT cycles.
module sched_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic n_rst,
  input  logic load,
  input  logic run,
  output logic tc
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!n_rst)            cnt <= '0;
    else if (load)         cnt <= W'(1);
    else if (run && !tc)   cnt <= cnt + W'(1);
  end

  assign tc = run && (cnt == W'(TIMEOUT));

endmodule

// File: rtl/vga_frame_sched.sv
// Frame scheduler: once every FRAME_DIV vsync edges, grants each enabled update
// client in index order during blanking. Define FRAME_SCHED_PERF_EN for max_busy.
module vga_frame_sched #(
  parameter int N_CLIENTS = 4,
  parameter int FRAME_DIV = 1,
  parameter int TIMEOUT   = 1023,
  parameter int V_ACTIVE  = vga_pkg::V_ACTIVE
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 vsync,
  input  logic [9:0]           y_pos,
  input  logic                 enable,
  input  logic [N_CLIENTS-1:0] client_en,
  input  logic [N_CLIENTS-1:0] client_done,
  input  logic                 clr_err,
  output logic [N_CLIENTS-1:0] client_go,
  output logic                 busy,
  output logic                 frame_tick,
  output logic [15:0]          frame_cnt,
  output logic                 overrun,
  output logic [N_CLIENTS-1:0] timeout_err
`ifdef FRAME_SCHED_PERF_EN
  ,
  output logic [15:0]          max_busy
`endif
);
  import vga_pkg::*;

  localparam int                   KW        = $clog2(N_CLIENTS + 1);
  localparam logic [7:0]           DIV_LAST  = 8'(FRAME_DIV - 1);
  localparam logic [N_CLIENTS-1:0] ONE       = N_CLIENTS'(1);
  localparam bit                   HAS_VIDEO = (V_ACTIVE > 0);

  sched_state_t   state;
  logic           vsync_q;
  logic [7:0]     div;
  logic [KW-1:0]  idx;
  logic [KW-1:0]  cur;
  logic [KW-1:0]  nxt_k;
  logic           nxt_found;
  logic           wd_tc;
  logic           vs_edge;
  logic           done_hit;
  logic           ov_evt;
  logic [N_CLIENTS-1:0] tmo_set;

  assign vs_edge  = vsync & ~vsync_q;
  assign done_hit = |(client_done & client_go);
  // Line 0 is the first visible line: still granting there means tearing risk.
  assign ov_evt   = busy && (vs_edge || (HAS_VIDEO && (y_pos == 10'd0)));
  assign tmo_set  = (state == GRANT && wd_tc && !done_hit) ? client_go : '0;

  // Lowest enabled client at or above idx; downward scan leaves the lowest hit.
  always_comb begin
    nxt_found = 1'b0;
    nxt_k     = '0;
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      if (client_en[i] && (KW'(i) >= idx)) begin
        nxt_found = 1'b1;
        nxt_k     = KW'(i);
      end
    end
  end

  sched_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk   (clk),
    .n_rst (n_rst),
    .load  (state == SELECT),
    .run   (state == GRANT),
    .tc    (wd_tc)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= IDLE;
      vsync_q    <= 1'b0;
      div        <= '0;
      idx        <= '0;
      cur        <= '0;
      client_go  <= '0;
      busy       <= 1'b0;
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      vsync_q    <= vsync;
      frame_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (vs_edge && enable) begin
            if (div == DIV_LAST) begin
              div   <= '0;
              idx   <= '0;
              state <= SELECT;
            end else begin
              div <= div + 8'd1;
            end
          end
        end
        SELECT: begin
          if (nxt_found) begin
            cur       <= nxt_k;
            client_go <= ONE << nxt_k;
            busy      <= 1'b1;
            state     <= GRANT;
          end else begin
            frame_tick <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
            state      <= DONE;
          end
        end
        GRANT: begin
          // done takes precedence over a coincident timeout (see tmo_set)
          if (done_hit || wd_tc) begin
            client_go <= '0;
            busy      <= 1'b0;
            idx       <= cur + KW'(1);
            state     <= SELECT;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky flags: a new error in the clr_err cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      overrun     <= 1'b0;
      timeout_err <= '0;
    end else begin
      overrun     <= (overrun & ~clr_err) | ov_evt;
      timeout_err <= (timeout_err & ~{N_CLIENTS{clr_err}}) | tmo_set;
    end
  end

`ifdef FRAME_SCHED_PERF_EN
  logic [15:0] seq_cyc;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      seq_cyc  <= '0;
      max_busy <= '0;
    end else begin
      if (state == IDLE)
        seq_cyc <= '0;
      else if ((state == SELECT || state == GRANT) && seq_cyc != 16'hFFFF)
        seq_cyc <= seq_cyc + 16'd1;
      if (state == DONE && seq_cyc > max_busy)
        max_busy <= seq_cyc;
      else if (clr_err)
        max_busy <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_vga_frame_sched.sv
// Randomized bench for vga_frame_sched: each started sequence is expanded into
// a per-cycle grant timeline from the scheduling rules and compared every cycle.
module tb_vga_frame_sched;

  localparam int N   = 4;
  localparam int DIV = 3;
  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         vsync = 1'b0;
  logic [9:0]   y_pos = 10'd490;
  logic         enable = 1'b0;
  logic [N-1:0] client_en = '0;
  logic [N-1:0] client_done = '0;
  logic         clr_err = 1'b0;
  logic [N-1:0] client_go;
  logic         busy;
  logic         frame_tick;
  logic [15:0]  frame_cnt;
  logic         overrun;
  logic [N-1:0] timeout_err;

  vga_frame_sched #(.N_CLIENTS(N), .FRAME_DIV(DIV), .TIMEOUT(TMO), .V_ACTIVE(480)) dut (
    .clk(clk), .n_rst(n_rst), .vsync(vsync), .y_pos(y_pos), .enable(enable),
    .client_en(client_en), .client_done(client_done), .clr_err(clr_err),
    .client_go(client_go), .busy(busy), .frame_tick(frame_tick),
    .frame_cnt(frame_cnt), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int           m_div  = 0;
  int           m_cnt  = 0;
  logic [N-1:0] m_terr = '0;
  logic         m_ov   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    check({tag, ".go"},   32'(client_go),  32'(0));
    check({tag, ".busy"}, 32'(busy),       32'(0));
    check({tag, ".tick"}, 32'(frame_tick), 32'(0));
    check({tag, ".cnt"},  32'(frame_cnt),  32'(16'(m_cnt)));
  endtask

  task automatic chk_flags(input string tag);
    check({tag, ".terr"}, 32'(timeout_err), 32'(m_terr));
    check({tag, ".ovr"},  32'(overrun),     32'(m_ov));
  endtask

  // One vsync pulse and, if it starts a sequence, the whole sequence.
  // resp<0: random response delay per client; mute bits never respond;
  // ov: hit line 0 and a second vsync edge during the first grant.
  task automatic frame(input logic en_vs, input logic [N-1:0] cen, input int resp,
                       input logic [N-1:0] mute, input bit ov);
    logic [N-1:0] exp_go   [0:127];
    logic [N-1:0] drv_done [0:127];
    logic         exp_tick [0:127];
    int s, g, g0, r, jend, len;
    bit start;
    client_en = cen;
    vsync     = 1'b1;
    enable    = en_vs;
    cyc();
    vsync = 1'b0;
    start = 1'b0;
    if (en_vs) begin
      if (m_div == DIV - 1) begin start = 1'b1; m_div = 0; end
      else m_div++;
    end
    if (!start) begin
      for (int a = 0; a < 2; a++) begin chk_idle("idle"); cyc(); end
      return;
    end
    for (int a = 0; a < 128; a++) begin
      exp_go[a] = '0; drv_done[a] = '0; exp_tick[a] = 1'b0;
    end
    s = 0; g0 = -1;
    for (int k = 0; k < N; k++) begin
      if (cen[k]) begin
        g = s + 1;
        if (g0 < 0) g0 = g;
        r = mute[k] ? 1000 : (resp >= 0 ? resp : int'($urandom_range(0, 20)));
        jend = (r < TMO) ? r : TMO - 1;
        for (int a = g; a <= g + jend; a++) exp_go[a][k] = 1'b1;
        if (r < TMO) drv_done[g + r][k] = 1'b1;
        else m_terr[k] = 1'b1;
        s = g + jend + 1;
      end
    end
    exp_tick[s + 1] = 1'b1;
    len = s + 3;
    if (ov && g0 >= 0) m_ov = 1'b1;
    for (int a = 0; a < len; a++) begin
      check("seq.go",   32'(client_go),  32'(exp_go[a]));
      check("seq.busy", 32'(busy),       32'(|exp_go[a]));
      check("seq.tick", 32'(frame_tick), 32'(exp_tick[a]));
      check("seq.cnt",  32'(frame_cnt),  32'(16'(m_cnt + ((a > s) ? 1 : 0))));
      client_done = drv_done[a] | (N'($urandom) & ~exp_go[a]);
      enable      = 1'($urandom_range(0, 1));
      if (ov && g0 >= 0 && a == g0 + 1) begin y_pos = 10'd0;   vsync = 1'b1; end
      else                              begin y_pos = 10'd490; vsync = 1'b0; end
      cyc();
    end
    client_done = '0;
    m_cnt++;
    chk_flags("seq");
  endtask

  task automatic clear_errs();
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    m_terr = '0;
    m_ov   = 1'b0;
    chk_flags("clr");
  endtask

  initial begin
    logic [N-1:0] rm;
    // reset state
    cyc(); cyc();
    chk_idle("rst");
    chk_flags("rst");
    n_rst = 1'b1;
    cyc();

    // normal: all clients, done 5 cycles into each grant
    repeat (DIV) frame(1'b1, 4'b1111, 5, 4'b0000, 1'b0);
    // skip disabled clients
    repeat (DIV) frame(1'b1, 4'b1010, -1, 4'b0000, 1'b0);
    // client 2 never answers; client 3 follows
    repeat (DIV) frame(1'b1, 4'b1100, 4, 4'b0100, 1'b0);
    clear_errs();
    // client 0 holds across line 0 and a second vsync edge
    repeat (DIV) frame(1'b1, 4'b0001, 0, 4'b0001, 1'b1);
    clear_errs();
    // enable low: edges ignored, divider holds, then three enabled edges start
    repeat (4) frame(1'b0, 4'b1111, 2, 4'b0000, 1'b0);
    repeat (DIV) frame(1'b1, 4'b1111, 2, 4'b0000, 1'b0);
    // no enabled clients: sequence still ticks
    repeat (DIV) frame(1'b1, 4'b0000, 0, 4'b0000, 1'b0);

    // random mix
    for (int i = 0; i < 60; i++) begin
      rm = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      frame(1'($urandom_range(0, 3) != 0), N'($urandom), -1, rm, 1'b0);
    end
    clear_errs();

    // reset while client 1 is granted; client_en drop must not revoke
    while (m_div != DIV - 1) frame(1'b1, 4'b0010, 3, 4'b0000, 1'b0);
    client_en = 4'b0010;
    enable    = 1'b1;
    vsync     = 1'b1;
    cyc();
    vsync = 1'b0;
    cyc();
    check("mid.go", 32'(client_go), 32'(4'b0010));
    client_en = 4'b0000;
    cyc();
    check("mid.hold", 32'(client_go), 32'(4'b0010));
    n_rst = 1'b0;
    cyc();
    m_div = 0; m_cnt = 0; m_terr = '0; m_ov = 1'b0;
    chk_idle("midrst");
    chk_flags("midrst");
    n_rst = 1'b1;
    cyc();
    repeat (DIV) frame(1'b1, 4'b1111, -1, 4'b0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
